cpu7_ifu_ibuf: RTL and testbench

Instruction buffer between the fetch datapath and the decoder in the cpu7 IFU. It captures each valid fetched instruction together with its PC and fetch-exception status into a small circular FIFO. It presents the oldest entry to decode. It decouples decode/EXU stalls from fetch: fetch is held only when the buffer is full, and the whole buffer is flushed on a branch redirect.

---
 rtl/cpu7_ifu_ibuf.sv | 95 +++++++++
 tb/tb_cpu7_ifu_ibuf.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cpu7_ifu_ibuf.sv
// Instruction buffer between fetch and decode: a small circular FIFO of
// {pc, inst, ex, exccode}, flushed on branch redirect, with no fetch-to-decode bypass.
module cpu7_ifu_ibuf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned GRLEN = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fdp_ibuf_valid,
  input  logic [GRLEN-1:0] fdp_ibuf_pc,
  input  logic [31:0]      fdp_ibuf_inst,
  input  logic             fdp_ibuf_ex,
  input  logic [5:0]       fdp_ibuf_exccode,
  output logic             ibuf_fdp_full,
  input  logic             br_cancel,
  input  logic             exu_ifu_stall_req,
  output logic             ibuf_dec_valid,
  output logic [GRLEN-1:0] ibuf_dec_pc,
  output logic [31:0]      ibuf_dec_inst,
  output logic             ibuf_dec_ex,
  output logic [5:0]       ibuf_dec_exccode,
  output logic [PTR_W:0]   ibuf_count
);

  localparam logic [PTR_W:0] LP_FULL_CNT = (PTR_W+1)'(DEPTH);

  // Storage is deliberately not reset; only pointers and count are.
  logic [GRLEN-1:0] r_pc      [DEPTH];
  logic [31:0]      r_inst    [DEPTH];
  logic             r_ex      [DEPTH];
  logic [5:0]       r_exccode [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_FULL_CNT);
  assign w_push  = fdp_ibuf_valid & ~w_full & ~br_cancel;
  assign w_pop   = ibuf_dec_valid & ~exu_ifu_stall_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (br_cancel) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_pc[r_wr_ptr]      <= fdp_ibuf_pc;
      r_inst[r_wr_ptr]    <= fdp_ibuf_inst;
      r_ex[r_wr_ptr]      <= fdp_ibuf_ex;
      r_exccode[r_wr_ptr] <= fdp_ibuf_exccode;
    end
  end

  // Valid drops in the same cycle as a redirect so decode never consumes a stale head.
  assign ibuf_dec_valid = ~w_empty & ~br_cancel;
  assign ibuf_fdp_full  = w_full;
  assign ibuf_count     = r_count;

  always_comb begin
    ibuf_dec_pc      = '0;
    ibuf_dec_inst    = '0;
    ibuf_dec_ex      = 1'b0;
    ibuf_dec_exccode = '0;
    if (!w_empty) begin
      ibuf_dec_pc      = r_pc[r_rd_ptr];
      ibuf_dec_inst    = r_inst[r_rd_ptr];
      ibuf_dec_ex      = r_ex[r_rd_ptr];
      ibuf_dec_exccode = r_exccode[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Self-checking bench for cpu7_ifu_ibuf: table-driven vectors plus a FIFO scoreboard model.
module tb_cpu7_ifu_ibuf;

  logic        clock = 1'b0;
  logic        reset;
  logic        fdp_ibuf_valid;
  logic [31:0] fdp_ibuf_pc;
  logic [31:0] fdp_ibuf_inst;
  logic        fdp_ibuf_ex;
  logic [5:0]  fdp_ibuf_exccode;
  logic        ibuf_fdp_full;
  logic        br_cancel;
  logic        exu_ifu_stall_req;
  logic        ibuf_dec_valid;
  logic [31:0] ibuf_dec_pc;
  logic [31:0] ibuf_dec_inst;
  logic        ibuf_dec_ex;
  logic [5:0]  ibuf_dec_exccode;
  logic [2:0]  ibuf_count;

  cpu7_ifu_ibuf #(
    .DEPTH (4),
    .PTR_W (2),
    .GRLEN (32)
  ) u_dut (
    .clock             (clock),
    .reset             (reset),
    .fdp_ibuf_valid    (fdp_ibuf_valid),
    .fdp_ibuf_pc       (fdp_ibuf_pc),
    .fdp_ibuf_inst     (fdp_ibuf_inst),
    .fdp_ibuf_ex       (fdp_ibuf_ex),
    .fdp_ibuf_exccode  (fdp_ibuf_exccode),
    .ibuf_fdp_full     (ibuf_fdp_full),
    .br_cancel         (br_cancel),
    .exu_ifu_stall_req (exu_ifu_stall_req),
    .ibuf_dec_valid    (ibuf_dec_valid),
    .ibuf_dec_pc       (ibuf_dec_pc),
    .ibuf_dec_inst     (ibuf_dec_inst),
    .ibuf_dec_ex       (ibuf_dec_ex),
    .ibuf_dec_exccode  (ibuf_dec_exccode),
    .ibuf_count        (ibuf_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  exc;
  } ent_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        stall;
    int          exp_count;
  } vec_t;

  ent_t sb[$];
  vec_t tbl[17];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic st, input int c);
    vec_t r;
    r.valid = v; r.pc = pc; r.stall = st; r.exp_count = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle, compares outputs against the model, then advances the model.
  task automatic step(input logic rst, input logic v, input logic [31:0] pc, input logic ex,
                      input logic [5:0] exc, input logic st, input logic cancel,
                      input bit do_chk, input int exp_cnt);
    logic exp_v;
    logic push;
    logic pop;
    ent_t e;
    @(negedge clock);
    reset = rst; fdp_ibuf_valid = v; fdp_ibuf_pc = pc; fdp_ibuf_inst = inst_of(pc);
    fdp_ibuf_ex = ex; fdp_ibuf_exccode = exc; exu_ifu_stall_req = st; br_cancel = cancel;
    #1;
    exp_v = (sb.size() > 0) && !cancel;
    if (do_chk) begin
      chk("dec_valid", 32'(ibuf_dec_valid), 32'(exp_v));
      chk("count", 32'(ibuf_count), 32'(sb.size()));
      chk("full", 32'(ibuf_fdp_full), 32'(sb.size() == 4));
      if (exp_cnt >= 0) chk("tbl_count", 32'(ibuf_count), 32'(exp_cnt));
      if (sb.size() > 0) begin
        chk("dec_pc", ibuf_dec_pc, sb[0].pc);
        chk("dec_inst", ibuf_dec_inst, sb[0].inst);
        chk("dec_ex", 32'(ibuf_dec_ex), 32'(sb[0].ex));
        chk("dec_exccode", 32'(ibuf_dec_exccode), 32'(sb[0].exc));
      end else begin
        chk("dec_pc_zero", ibuf_dec_pc, 32'h0);
        chk("dec_inst_zero", ibuf_dec_inst, 32'h0);
        chk("dec_ex_zero", {25'h0, ibuf_dec_ex, ibuf_dec_exccode}, 32'h0);
      end
    end
    push = v && (sb.size() != 4) && !cancel;
    pop  = exp_v && !st;
    if (rst || cancel) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) begin
        e.pc = pc; e.inst = inst_of(pc); e.ex = ex; e.exc = exc;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    // Three back-to-back pushes with no stall, then a stalled fill past full and a drain.
    tbl[0]  = mk(1'b1, 32'h1c000000, 1'b0, 0);
    tbl[1]  = mk(1'b1, 32'h1c000004, 1'b0, 1);
    tbl[2]  = mk(1'b1, 32'h1c000008, 1'b0, 1);
    tbl[3]  = mk(1'b0, 32'h0,        1'b0, 1);
    tbl[4]  = mk(1'b0, 32'h0,        1'b0, 0);
    tbl[5]  = mk(1'b1, 32'h1c000010, 1'b1, 0);
    tbl[6]  = mk(1'b1, 32'h1c000014, 1'b1, 1);
    tbl[7]  = mk(1'b1, 32'h1c000018, 1'b1, 2);
    tbl[8]  = mk(1'b1, 32'h1c00001c, 1'b1, 3);
    tbl[9]  = mk(1'b1, 32'h1c000020, 1'b1, 4);
    tbl[10] = mk(1'b1, 32'h1c000020, 1'b1, 4);
    tbl[11] = mk(1'b1, 32'h1c000020, 1'b0, 4);
    tbl[12] = mk(1'b1, 32'h1c000020, 1'b0, 3);
    tbl[13] = mk(1'b0, 32'h0,        1'b0, 3);
    tbl[14] = mk(1'b0, 32'h0,        1'b0, 2);
    tbl[15] = mk(1'b0, 32'h0,        1'b0, 1);
    tbl[16] = mk(1'b0, 32'h0,        1'b0, 0);

    reset = 1'b1; fdp_ibuf_valid = 1'b0; fdp_ibuf_pc = '0; fdp_ibuf_inst = '0;
    fdp_ibuf_ex = 1'b0; fdp_ibuf_exccode = '0; exu_ifu_stall_req = 1'b0; br_cancel = 1'b0;
    step(1'b1, 1'b0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b0, -1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b0, -1);

    foreach (tbl[i])
      step(1'b0, tbl[i].valid, tbl[i].pc, 1'b0, 6'h0, tbl[i].stall, 1'b0, 1'b1, tbl[i].exp_count);

    // Flush with 3 entries held and fetch valid in the same cycle.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h1c000040 + 32'(4 * i), 1'b0, 6'h0, 1'b1, 1'b0, 1'b1, i);
    step(1'b0, 1'b1, 32'h1c00004c, 1'b0, 6'h0, 1'b1, 1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 32'h1c000100, 1'b0, 6'h0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 32'h0,        1'b0, 6'h0, 1'b0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0,        1'b0, 6'h0, 1'b0, 1'b0, 1'b1, 0);

    // Exception entry sandwiched between two normal entries.
    step(1'b0, 1'b1, 32'h1c000200, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 32'h1c000204, 1'b1, 6'h08, 1'b0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 32'h1c000208, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 0);

    // Ten streaming entries wrap both pointers, then reset lands mid-stream.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 32'h1c000300 + 32'(4 * i), 1'b0, 6'h0, 1'b0, 1'b0, 1'b1, (i == 0) ? 0 : 1);
    step(1'b1, 1'b1, 32'h1c000328, 1'b0, 6'h0, 1'b0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0,        1'b0, 6'h0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 32'h0,        1'b0, 6'h0, 1'b1, 1'b0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
